// File: rtl/udp_demux_pkg.sv
// Shared types for the UDP destination-port demultiplexer.
//   state_e   : frame-level control state (IDLE / FWD / DROP)
//   udp_hdr_t : IP + UDP header fields captured when a header is accepted
//   sat_inc   : 32-bit saturating increment used by the optional counters
package udp_demux_pkg;

  localparam int PORT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]       source_ip;
    logic [31:0]       dest_ip;
    logic [PORT_W-1:0] source_port;
    logic [PORT_W-1:0] dest_port;
    logic [PORT_W-1:0] length;
    logic [PORT_W-1:0] checksum;
  } udp_hdr_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/udp_demux_match.sv
// Combinational priority matcher.
//   cfg_enable/cfg_port/cfg_mask : per-output match rules (mask bit 1 = compare)
//   dest_port                    : destination port of the offered header
//   hit / sel                    : some enabled rule matched / lowest matching index
module udp_demux_match
  import udp_demux_pkg::*;
#(
  parameter int M_COUNT = 4,
  parameter int SEL_W   = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic [M_COUNT-1:0]        cfg_enable,
  input  logic [M_COUNT*PORT_W-1:0] cfg_port,
  input  logic [M_COUNT*PORT_W-1:0] cfg_mask,
  input  logic [PORT_W-1:0]         dest_port,
  output logic                      hit,
  output logic [SEL_W-1:0]          sel
);

  // Scanning from the top down lets the lowest matching index overwrite
  // any higher one, which gives lowest-index priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    hit = 1'b0;
    sel = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (cfg_enable[i] &&
          (((dest_port ^ cfg_port[i*PORT_W +: PORT_W]) &
            cfg_mask[i*PORT_W +: PORT_W]) == '0)) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/udp_port_demux_64.sv
// UDP destination-port demultiplexer, 64-bit payload datapath.
// Steers each header+payload frame to one of M_COUNT outputs chosen by the
// udp_demux_match priority matcher; frames matching no enabled rule are
// consumed and discarded.
//   clk, rst (async, active-high)
//   cfg_enable/cfg_port/cfg_mask         : match rules, sampled at header accept
//   s_udp_hdr_* / s_ip_* / s_udp_*       : input header handshake + fields
//   s_udp_payload_axis_*                 : input payload stream
//   m_udp_hdr_valid/ready [M_COUNT]      : per-output header handshake
//   m_ip_* / m_udp_*                     : shared registered header fields
//   m_udp_payload_axis_*                 : shared payload, per-output valid/ready
//   busy                                 : frame in progress (state != IDLE)
// Optional build macro UDP_DEMUX_STATS_EN adds saturating frame counters
// stat_drop_frames and stat_fwd_frames (32 bits per output).
module udp_port_demux_64
  import udp_demux_pkg::*;
#(
  parameter int M_COUNT = 4,
  parameter int SEL_W   = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [M_COUNT-1:0]        cfg_enable,
  input  logic [M_COUNT*16-1:0]     cfg_port,
  input  logic [M_COUNT*16-1:0]     cfg_mask,
  input  logic                      s_udp_hdr_valid,
  output logic                      s_udp_hdr_ready,
  input  logic [31:0]               s_ip_source_ip,
  input  logic [31:0]               s_ip_dest_ip,
  input  logic [15:0]               s_udp_source_port,
  input  logic [15:0]               s_udp_dest_port,
  input  logic [15:0]               s_udp_length,
  input  logic [15:0]               s_udp_checksum,
  input  logic [63:0]               s_udp_payload_axis_tdata,
  input  logic [7:0]                s_udp_payload_axis_tkeep,
  input  logic                      s_udp_payload_axis_tvalid,
  output logic                      s_udp_payload_axis_tready,
  input  logic                      s_udp_payload_axis_tlast,
  input  logic                      s_udp_payload_axis_tuser,
  output logic [M_COUNT-1:0]        m_udp_hdr_valid,
  input  logic [M_COUNT-1:0]        m_udp_hdr_ready,
  output logic [31:0]               m_ip_source_ip,
  output logic [31:0]               m_ip_dest_ip,
  output logic [15:0]               m_udp_source_port,
  output logic [15:0]               m_udp_dest_port,
  output logic [15:0]               m_udp_length,
  output logic [15:0]               m_udp_checksum,
  output logic [63:0]               m_udp_payload_axis_tdata,
  output logic [7:0]                m_udp_payload_axis_tkeep,
  output logic [M_COUNT-1:0]        m_udp_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]        m_udp_payload_axis_tready,
  output logic                      m_udp_payload_axis_tlast,
  output logic                      m_udp_payload_axis_tuser,
  output logic                      busy
`ifdef UDP_DEMUX_STATS_EN
  ,
  output logic [31:0]               stat_drop_frames,
  output logic [M_COUNT*32-1:0]     stat_fwd_frames
`endif
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  udp_hdr_t         hdr_q, hdr_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic             tvalid_q, tvalid_d;
  logic [63:0]      tdata_q, tdata_d;
  logic [7:0]       tkeep_q, tkeep_d;
  logic             tlast_q, tlast_d;
  logic             tuser_q, tuser_d;

  logic               match_hit;
  logic [SEL_W-1:0]   match_sel;
  logic [M_COUNT-1:0] sel_onehot;
  logic               m_hdr_ready_sel, m_tready_sel;
  logic               hdr_accept, in_beat, out_pop;

  udp_demux_match #(.M_COUNT(M_COUNT), .SEL_W(SEL_W)) u_match (
    .cfg_enable (cfg_enable),
    .cfg_port   (cfg_port),
    .cfg_mask   (cfg_mask),
    .dest_port  (s_udp_dest_port),
    .hit        (match_hit),
    .sel        (match_sel)
  );

  // Handshakes. Ready/valid of unselected outputs are masked out via the
  // one-hot of the latched select.
  always_comb begin
    sel_onehot      = M_COUNT'(1) << sel_q;
    m_hdr_ready_sel = |(m_udp_hdr_ready & sel_onehot);
    m_tready_sel    = |(m_udp_payload_axis_tready & sel_onehot);
    // A new header waits until the previous frame's header and last beat
    // have both left the output registers.
    s_udp_hdr_ready = !rst && (state_q == IDLE) && !hdr_valid_q && !tvalid_q;
    unique case (state_q)
      FWD:     s_udp_payload_axis_tready = !tvalid_q || m_tready_sel;
      DROP:    s_udp_payload_axis_tready = 1'b1;
      default: s_udp_payload_axis_tready = 1'b0;
    endcase
    hdr_accept = s_udp_hdr_valid && s_udp_hdr_ready;
    in_beat    = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
    out_pop    = tvalid_q && m_tready_sel;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    hdr_d       = hdr_q;
    hdr_valid_d = hdr_valid_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;

    if (hdr_valid_q && m_hdr_ready_sel) hdr_valid_d = 1'b0;
    if (out_pop)                        tvalid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hdr_accept) begin
          hdr_d = '{source_ip:   s_ip_source_ip,
                    dest_ip:     s_ip_dest_ip,
                    source_port: s_udp_source_port,
                    dest_port:   s_udp_dest_port,
                    length:      s_udp_length,
                    checksum:    s_udp_checksum};
          if (match_hit) begin
            sel_d       = match_sel;
            hdr_valid_d = 1'b1;
            state_d     = FWD;
          end else begin
            state_d = DROP;
          end
        end
      end
      FWD: begin
        // A beat accepted in the same cycle the register drains simply
        // reloads it, keeping tvalid high for full throughput.
        if (in_beat) begin
          tvalid_d = 1'b1;
          tdata_d  = s_udp_payload_axis_tdata;
          tkeep_d  = s_udp_payload_axis_tkeep;
          tlast_d  = s_udp_payload_axis_tlast;
          tuser_d  = s_udp_payload_axis_tuser;
          if (s_udp_payload_axis_tlast) state_d = IDLE;
        end
      end
      DROP: begin
        if (in_beat && s_udp_payload_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the header and data registers are reset as well, so the shared
  // output fields read as zero after reset rather than holding X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge regardless of statement order.
      state_q     <= state_d;
      sel_q       <= sel_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
    end
  end

  assign m_udp_hdr_valid           = hdr_valid_q ? sel_onehot : '0;
  assign m_udp_payload_axis_tvalid = tvalid_q ? sel_onehot : '0;
  assign m_ip_source_ip            = hdr_q.source_ip;
  assign m_ip_dest_ip              = hdr_q.dest_ip;
  assign m_udp_source_port         = hdr_q.source_port;
  assign m_udp_dest_port           = hdr_q.dest_port;
  assign m_udp_length              = hdr_q.length;
  assign m_udp_checksum            = hdr_q.checksum;
  assign m_udp_payload_axis_tdata  = tdata_q;
  assign m_udp_payload_axis_tkeep  = tkeep_q;
  assign m_udp_payload_axis_tlast  = tlast_q;
  assign m_udp_payload_axis_tuser  = tuser_q;
  assign busy                      = (state_q != IDLE);

`ifdef UDP_DEMUX_STATS_EN
  logic [31:0] stat_drop_q, stat_drop_d;
  logic [31:0] stat_fwd_q [M_COUNT];
  logic [31:0] stat_fwd_d [M_COUNT];

  always_comb begin
    stat_drop_d = stat_drop_q;
    for (int i = 0; i < M_COUNT; i++) stat_fwd_d[i] = stat_fwd_q[i];
    if (hdr_accept) begin
      if (!match_hit) stat_drop_d = sat_inc(stat_drop_q);
      for (int i = 0; i < M_COUNT; i++) begin
        if (match_hit && (match_sel == SEL_W'(i))) stat_fwd_d[i] = sat_inc(stat_fwd_q[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_drop_q <= '0;
      for (int i = 0; i < M_COUNT; i++) stat_fwd_q[i] <= '0;
    end else begin
      stat_drop_q <= stat_drop_d;
      for (int i = 0; i < M_COUNT; i++) stat_fwd_q[i] <= stat_fwd_d[i];
    end
  end

  assign stat_drop_frames = stat_drop_q;
  for (genvar g = 0; g < M_COUNT; g++) begin : g_stat_out
    assign stat_fwd_frames[g*32 +: 32] = stat_fwd_q[g];
  end
`endif

endmodule

// File: tb/tb_udp_port_demux_64.sv
// Directed self-checking bench for udp_port_demux_64 (M_COUNT = 4).
// Inputs change 1 ns after a rising edge; handshakes are sampled on the
// falling edge and take effect at the following rising edge.
module tb_udp_port_demux_64;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [M-1:0]    cfg_enable;
  logic [M*16-1:0] cfg_port, cfg_mask;
  logic            s_udp_hdr_valid, s_udp_hdr_ready;
  logic [31:0]     s_ip_source_ip, s_ip_dest_ip;
  logic [15:0]     s_udp_source_port, s_udp_dest_port, s_udp_length, s_udp_checksum;
  logic [63:0]     s_tdata;
  logic [7:0]      s_tkeep;
  logic            s_tvalid, s_tready, s_tlast, s_tuser;
  logic [M-1:0]    m_udp_hdr_valid, m_udp_hdr_ready;
  logic [31:0]     m_ip_source_ip, m_ip_dest_ip;
  logic [15:0]     m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
  logic [63:0]     m_tdata;
  logic [7:0]      m_tkeep;
  logic [M-1:0]    m_tvalid, m_tready;
  logic            m_tlast, m_tuser, busy;
`ifdef UDP_DEMUX_STATS_EN
  logic [31:0]     stat_drop_frames;
  logic [M*32-1:0] stat_fwd_frames;
`endif

  udp_port_demux_64 #(.M_COUNT(M)) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_port(cfg_port), .cfg_mask(cfg_mask),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
    .s_udp_source_port(s_udp_source_port), .s_udp_dest_port(s_udp_dest_port),
    .s_udp_length(s_udp_length), .s_udp_checksum(s_udp_checksum),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tkeep(s_tkeep),
    .s_udp_payload_axis_tvalid(s_tvalid), .s_udp_payload_axis_tready(s_tready),
    .s_udp_payload_axis_tlast(s_tlast), .s_udp_payload_axis_tuser(s_tuser),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
    .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
    .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
    .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
    .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tready(m_tready),
    .m_udp_payload_axis_tlast(m_tlast), .m_udp_payload_axis_tuser(m_tuser),
    .busy(busy)
`ifdef UDP_DEMUX_STATS_EN
    , .stat_drop_frames(stat_drop_frames), .stat_fwd_frames(stat_fwd_frames)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; logic [63:0] data; logic [7:0] keep; logic last; logic user; } beat_t;
  typedef struct { int ch; logic [15:0] port; logic [31:0] dip; logic [15:0] len; } hdr_rec_t;
  beat_t    beat_q[$];
  hdr_rec_t hdr_q[$];
  int viol_bp = 0;
  int viol_onehot = 0;

  // Output monitor: logs every handshake that will complete at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < M; i++) begin
        if (m_udp_hdr_valid[i] && m_udp_hdr_ready[i])
          hdr_q.push_back('{i, m_udp_dest_port, m_ip_dest_ip, m_udp_length});
        if (m_tvalid[i] && m_tready[i])
          beat_q.push_back('{i, m_tdata, m_tkeep, m_tlast, m_tuser});
      end
      if ($countones(m_udp_hdr_valid) > 1 || $countones(m_tvalid) > 1) viol_onehot <= viol_onehot + 1;
      if ((|m_tvalid) && !(|(m_tvalid & m_tready)) && s_tready) viol_bp <= viol_bp + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [7:0] base, input int i);
    return {base, 8'(i), 16'hA5C3, 32'(i) * 32'h0101_0101};
  endfunction

  // Called 1 ns after a rising edge; returns 1 ns after the accepting edge.
  task automatic hdr_xfer(input logic [15:0] port);
    logic acc;
    acc = 1'b0;
    s_udp_hdr_valid   = 1'b1;
    s_udp_dest_port   = port;
    s_ip_dest_ip      = {16'hC0A8, port};
    s_udp_length      = port + 16'd8;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk); acc = s_udp_hdr_ready;
      @(posedge clk); #1;
    end
    s_udp_hdr_valid = 1'b0;
    if (!acc) check("hdr_timeout", 0, 1);
  endtask

  task automatic send_beats(input logic [7:0] base, input int n, input logic with_last, output int stalls);
    logic acc;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      acc      = 1'b0;
      s_tdata  = beat_data(base, i);
      s_tlast  = with_last && (i == n - 1);
      s_tkeep  = s_tlast ? 8'h0F : 8'hFF;
      s_tuser  = (i % 2) == 1;
      s_tvalid = 1'b1;
      for (int k = 0; k < 200 && !acc; k++) begin
        if (rand_bp) m_tready = 4'($urandom_range(0, 15));
        @(negedge clk); acc = s_tready;
        @(posedge clk); #1;
        if (!acc) stalls++;
      end
      if (!acc) begin
        check("beat_timeout", 0, 1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    rand_bp = 1'b0;
    m_tready = '1;
    m_udp_hdr_ready = '1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk); done = !busy && (m_udp_hdr_valid == 0) && (m_tvalid == 0);
      @(posedge clk); #1;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic check_hdr(input string tag, input int idx, input int ch, input logic [15:0] port);
    if (idx < hdr_q.size()) begin
      check({tag, "_hdr_ch"},   hdr_q[idx].ch, ch);
      check({tag, "_hdr_port"}, hdr_q[idx].port, port);
      check({tag, "_hdr_dip"},  hdr_q[idx].dip, {16'hC0A8, port});
      check({tag, "_hdr_len"},  hdr_q[idx].len, port + 16'd8);
    end else check({tag, "_hdr_missing"}, 0, 1);
  endtask

  task automatic check_frame(input string tag, input int start, input int ch, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      if (start + i < beat_q.size()) begin
        check($sformatf("%s_ch%0d", tag, i),   beat_q[start+i].ch, ch);
        check($sformatf("%s_data%0d", tag, i), beat_q[start+i].data, beat_data(base, i));
        check($sformatf("%s_last%0d", tag, i), beat_q[start+i].last, i == n - 1);
        check($sformatf("%s_keep%0d", tag, i), beat_q[start+i].keep, (i == n - 1) ? 8'h0F : 8'hFF);
        check($sformatf("%s_user%0d", tag, i), beat_q[start+i].user, (i % 2) == 1);
      end
    end
  endtask

  initial begin
    int b0, h0, st, rel_c, acc_c;
    rst = 1'b1;
    cfg_enable = '0; cfg_port = '0; cfg_mask = '0;
    s_udp_hdr_valid = 1'b0;
    s_ip_source_ip = 32'h0A00_0001; s_ip_dest_ip = '0;
    s_udp_source_port = 16'd4242; s_udp_dest_port = '0;
    s_udp_length = '0; s_udp_checksum = 16'hBEEF;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_udp_hdr_ready = '1; m_tready = '1;
    #3;
    check("rst_hdr_ready", s_udp_hdr_ready, 0);
    check("rst_tready",    s_tready, 0);
    check("rst_hdr_valid", m_udp_hdr_valid, 0);
    check("rst_tvalid",    m_tvalid, 0);
    check("rst_busy",      busy, 0);
    check("rst_dport",     m_udp_dest_port, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); check("idle_hdr_ready", s_udp_hdr_ready, 1);
    @(posedge clk); #1;

    // Exact match to output 1.
    cfg_enable = 4'b0011;
    cfg_port = {16'd0, 16'd0, 16'd5000, 16'd80};
    cfg_mask = {16'h0, 16'h0, 16'hFFFF, 16'hFFFF};
    b0 = beat_q.size(); h0 = hdr_q.size();
    hdr_xfer(16'd5000);
    check("t1_hdr_valid", m_udp_hdr_valid, 4'b0010);
    check("t1_busy", busy, 1);
    send_beats(8'h10, 3, 1'b1, st);
    check("t1_stalls", st, 0);
    wait_idle();
    check("t1_nhdr", hdr_q.size() - h0, 1);
    check_hdr("t1", h0, 1, 16'd5000);
    check("t1_nbeats", beat_q.size() - b0, 3);
    check_frame("t1", b0, 1, 3, 8'h10);
`ifdef UDP_DEMUX_STATS_EN
    check("t1_stat_fwd1", stat_fwd_frames[63:32], 1);
`endif

    // Both rules match; lowest index wins. Config changes mid-frame are ignored.
    cfg_port = {16'd0, 16'd0, 16'd5000, 16'd0};
    cfg_mask = {16'h0, 16'h0, 16'h0000, 16'h0000};
    b0 = beat_q.size(); h0 = hdr_q.size();
    hdr_xfer(16'd80);
    check("t2_hdr_valid", m_udp_hdr_valid, 4'b0001);
    cfg_enable = 4'b0000;
    send_beats(8'h20, 2, 1'b1, st);
    wait_idle();
    check("t2_nhdr", hdr_q.size() - h0, 1);
    check_hdr("t2", h0, 0, 16'd80);
    check("t2_nbeats", beat_q.size() - b0, 2);
    check_frame("t2", b0, 0, 2, 8'h20);

    // No match: frame dropped at full rate.
    cfg_enable = 4'b0011;
    cfg_port = {16'd0, 16'd0, 16'd5000, 16'd80};
    cfg_mask = {16'h0, 16'h0, 16'hFFFF, 16'hFFFF};
    b0 = beat_q.size(); h0 = hdr_q.size();
    hdr_xfer(16'd1234);
    check("t3_hdr_valid", m_udp_hdr_valid, 0);
    check("t3_busy", busy, 1);
    send_beats(8'h30, 5, 1'b1, st);
    check("t3_stalls", st, 0);
    wait_idle();
    check("t3_nhdr", hdr_q.size() - h0, 0);
    check("t3_nbeats", beat_q.size() - b0, 0);
`ifdef UDP_DEMUX_STATS_EN
    check("t3_stat_drop", stat_drop_frames, 1);
`endif

    // 64-beat frame to output 2 under random backpressure.
    cfg_enable = 4'b0111;
    cfg_port = {16'd7001, 16'd7000, 16'd5000, 16'd80};
    cfg_mask = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    b0 = beat_q.size(); h0 = hdr_q.size();
    hdr_xfer(16'd7000);
    rand_bp = 1'b1;
    send_beats(8'h40, 64, 1'b1, st);
    wait_idle();
    check("t4_nhdr", hdr_q.size() - h0, 1);
    check_hdr("t4", h0, 2, 16'd7000);
    check("t4_nbeats", beat_q.size() - b0, 64);
    check_frame("t4", b0, 2, 64, 8'h40);

    // Back-to-back frames; second header held off by output 2's header stall.
    cfg_enable = 4'b1111;
    b0 = beat_q.size(); h0 = hdr_q.size();
    m_udp_hdr_ready = 4'b1011;
    hdr_xfer(16'd7000);
    send_beats(8'h50, 2, 1'b1, st);
    rel_c = 0; acc_c = 0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1 m_udp_hdr_ready = 4'b1111;
        rel_c = cyc;
      end
      begin
        hdr_xfer(16'd7001);
        acc_c = cyc;
      end
    join
    check("t5_accept_delay", acc_c - rel_c, 2);
    send_beats(8'h60, 2, 1'b1, st);
    wait_idle();
    check("t5_nhdr", hdr_q.size() - h0, 2);
    check_hdr("t5a", h0, 2, 16'd7000);
    check_hdr("t5b", h0 + 1, 3, 16'd7001);
    check("t5_nbeats", beat_q.size() - b0, 4);
    check_frame("t5a", b0, 2, 2, 8'h50);
    check_frame("t5b", b0 + 2, 3, 2, 8'h60);

    // Reset in the middle of a frame, then a clean frame to output 3.
    m_udp_hdr_ready = 4'b1011;
    m_tready = 4'b0000;
    hdr_xfer(16'd7000);
    send_beats(8'h70, 1, 1'b0, st);
    s_tdata = beat_data(8'h70, 1); s_tkeep = 8'hFF; s_tvalid = 1'b1;
    @(negedge clk);
    check("t6_stall", s_tready, 0);
    check("t6_pre_hdr_valid", m_udp_hdr_valid, 4'b0100);
    check("t6_pre_tvalid", m_tvalid, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_hdr_valid", m_udp_hdr_valid, 0);
    check("t6_rst_tvalid", m_tvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_tready", s_tready, 0);
    s_tvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
`ifdef UDP_DEMUX_STATS_EN
    check("t6_stat_drop_rst", stat_drop_frames, 0);
`endif
    m_tready = '1; m_udp_hdr_ready = '1;
    b0 = beat_q.size(); h0 = hdr_q.size();
    hdr_xfer(16'd7001);
    check("t6_hdr_valid", m_udp_hdr_valid, 4'b1000);
    send_beats(8'h80, 3, 1'b1, st);
    wait_idle();
    check("t6_nhdr", hdr_q.size() - h0, 1);
    check_hdr("t6", h0, 3, 16'd7001);
    check("t6_nbeats", beat_q.size() - b0, 3);
    check_frame("t6", b0, 3, 3, 8'h80);

    check("bp_rule", viol_bp, 0);
    check("onehot_rule", viol_onehot, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
